// File: rtl/imm_encoder.sv
// Packs an immediate and register fields into a 32-bit RISC-V instruction word.
// Each result is tagged with a sequential address and a range-error flag, then held in a 2-entry FIFO.
module imm_encoder #(
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             ImmSrc,
    input  logic [31:0]            imm,
    input  logic [6:0]             opcode,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [2:0]             funct3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic                   imm_err,
    output logic [15:0]            err_count
);

    logic [31:0]            enc_instr;
    logic                   enc_err;
    logic                   push, pop;

    logic [1:0]             count_q, count_d;
    logic [INSTR_WIDTH-1:0] head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
    logic [ADDR_WIDTH-1:0]  head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;
    logic                   head_err_q, head_err_d, tail_err_q, tail_err_d;
    logic [ADDR_WIDTH-1:0]  addr_cnt_q, addr_cnt_d;
    logic [15:0]            err_count_q, err_count_d;

    // Encoders 5-7 fall back to the I-type packing and range rule.
    always_comb begin
        enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err   = !((&imm[31:11]) || (~|imm[31:11]));
        case (ImmSrc)
            3'd1: enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'd2: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err   = !((&imm[31:12]) || (~|imm[31:12])) || imm[0];
            end
            3'd3: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err   = !((&imm[31:20]) || (~|imm[31:20])) || imm[0];
            end
            3'd4: begin
                enc_instr = {imm[31:12], rd, opcode};
                enc_err   = |imm[11:0];
            end
            default: ;
        endcase
    end

    // rst_n gates in_ready so nothing is accepted while the buffer is being cleared.
    assign in_ready  = rst_n && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_addr_d  = head_addr_q;
        head_err_d   = head_err_q;
        tail_instr_d = tail_instr_q;
        tail_addr_d  = tail_addr_q;
        tail_err_d   = tail_err_q;
        addr_cnt_d   = addr_cnt_q;
        err_count_d  = err_count_q;

        if (push) begin
            addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(4);
            if (enc_err && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end

        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_instr_d = INSTR_WIDTH'(enc_instr);
                    head_addr_d  = addr_cnt_q;
                    head_err_d   = enc_err;
                end else begin
                    tail_instr_d = INSTR_WIDTH'(enc_instr);
                    tail_addr_d  = addr_cnt_q;
                    tail_err_d   = enc_err;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_instr_d = tail_instr_q;
                head_addr_d  = tail_addr_q;
                head_err_d   = tail_err_q;
                count_d      = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_instr_d = INSTR_WIDTH'(enc_instr);
                    head_addr_d  = addr_cnt_q;
                    head_err_d   = enc_err;
                end else begin
                    head_instr_d = tail_instr_q;
                    head_addr_d  = tail_addr_q;
                    head_err_d   = tail_err_q;
                    tail_instr_d = INSTR_WIDTH'(enc_instr);
                    tail_addr_d  = addr_cnt_q;
                    tail_err_d   = enc_err;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q      <= 2'd0;
            head_instr_q <= '0;
            head_addr_q  <= BASE_ADDR;
            head_err_q   <= 1'b0;
            tail_instr_q <= '0;
            tail_addr_q  <= BASE_ADDR;
            tail_err_q   <= 1'b0;
            addr_cnt_q   <= BASE_ADDR;
            err_count_q  <= 16'd0;
        end else begin
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_addr_q  <= head_addr_d;
            head_err_q   <= head_err_d;
            tail_instr_q <= tail_instr_d;
            tail_addr_q  <= tail_addr_d;
            tail_err_q   <= tail_err_d;
            addr_cnt_q   <= addr_cnt_d;
            err_count_q  <= err_count_d;
        end
    end

    assign instr     = head_instr_q;
    assign addr      = head_addr_q;
    assign imm_err   = head_err_q;
    assign err_count = err_count_q;

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 32, the instruction width (only 32 is supported).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the width of the instruction address.
REQ-003 SHALL have parameter BASE_ADDR, default 0, the first address issued after reset.
REQ-004 SHALL have one clock and synchronous active-low reset: clk input 1, rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  request accepted when in_valid && in_ready at the clk edge.
REQ-008 ImmSrc  input  3  immediate type: 0 Imm, 1 Store, 2 Branch, 3 Jump, 4 UppImm.
REQ-009 imm  input  32  signed byte-offset or immediate value to encode.
REQ-010 opcode  input  7; rd  input  5; rs1  input  5; rs2  input  5; funct3  input  3: instruction fields.
REQ-011 out_valid  output  1; out_ready  input  1: output handshake, transfer when both are high.
REQ-012 instr  output  INSTR_WIDTH  encoded instruction at the buffer head.
REQ-013 addr  output  ADDR_WIDTH  address assigned to the head instruction.
REQ-014 imm_err  output  1  the head immediate was not representable.
REQ-015 err_count  output  16  number of accepted requests with an encoding error.

Function
REQ-016 SHALL pack instr as the inverse of the core immediate decode, as follows.
- Imm: {imm[11:0], rs1, funct3, rd, opcode}.
- Store: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- Branch: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Jump: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- UppImm: {imm[31:12], rd, opcode}.
REQ-017 SHALL encode ImmSrc values 5-7 as Imm, with imm_err computed by the Imm rule.
REQ-018 SHALL set the per-entry error flag under these conditions.
- Imm/Store: imm[31:11] not all equal.
- Branch: imm[31:12] not all equal, or imm[0]=1.
- Jump: imm[31:20] not all equal, or imm[0]=1.
- UppImm: imm[11:0] is not 0.
REQ-019 SHALL still emit the truncated encoding when the error flag is set; the entry is never dropped.
REQ-020 When the error flag is clear, decoding instr with the same ImmSrc SHALL reproduce imm exactly.
REQ-021 SHALL store {instr, addr, err} in a 2-entry in-order FIFO; out_valid = FIFO non-empty.
REQ-022 in_ready SHALL be 1 iff the FIFO count < 2, derived from registered state only (not from out_ready).
REQ-023 Latency SHALL be one cycle: a request accepted at edge N is at the head (out_valid=1) after edge N when the FIFO was empty.
REQ-024 On simultaneous push and pop, the count SHALL be unchanged and order preserved; a push while full is impossible.
REQ-025 instr/addr/imm_err SHALL hold stable while out_valid && !out_ready.
REQ-026 The address counter SHALL be assigned on accept, then advance by 4, wrapping modulo 2^ADDR_WIDTH.
REQ-027 err_count SHALL increment on each accepted request with an error and saturate at 0xFFFF.

Reset
REQ-028 While rst_n=0 at an edge, the block SHALL reset as follows.
- FIFO emptied: out_valid=0, in_ready=0 during reset.
- Address counter set to BASE_ADDR; err_count=0.
- instr=0, addr=BASE_ADDR, imm_err=0.
REQ-029 in_ready SHALL be 1 in the first cycle after rst_n returns to 1.
REQ-030 A reset mid-operation SHALL discard buffered entries, and the next accept SHALL get BASE_ADDR.

Verification
REQ-031 Imm case: ImmSrc=0, imm=0xFFFFFFFF, rd=1, rs1=2, funct3=0, opcode=0x13 -> instr=0xFFF10093, addr=0x0, imm_err=0.
REQ-032 Branch case: ImmSrc=2, imm=8, rs1=1, rs2=2, funct3=0, opcode=0x63 -> instr=0x00208463, imm_err=0; the same request with imm=7 -> imm_err=1, err_count=1.
REQ-033 Jump case: ImmSrc=3, imm=0x800, rd=1, opcode=0x6F -> instr=0x001000EF; the same request with imm=0x100000 -> imm_err=1.
REQ-034 Backpressure: out_ready=0, three back-to-back requests -> the first two are accepted and in_ready=0; after out_ready=1 the outputs appear in order with addr 0x0, 0x4, 0x8.
REQ-035 Reset with 2 entries buffered -> out_valid=0 after the edge, err_count=0, next output addr=BASE_ADDR.
REQ-036 Random round-trip: 10k random in-range requests per type -> decoded immediate equals imm, and push/pop at the same edge never loses an entry.
